// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: writer side of the instruction RAM port.
// Packs a stream of 16-bit halfwords (opcode, a, b, c) into 64-bit
// instruction words and writes them to consecutive RAM addresses until an
// OP_EOF (opcode 0) instruction has been written, or the RAM is full.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing
// 16-bit checksum halfword after the EOF instruction.
module instruction_ram_loader #(
  parameter int          DEPTH        = 256,
  parameter logic [15:0] BASE_ADDRESS = 16'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] ram_address,
  output logic [63:0] ram_data,
  output logic        ram_wren,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  // opcode, a, b of the instruction being collected; c goes straight to ram_data
  logic [47:0] pack_q, pack_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] ram_address_q, ram_address_d;
  logic [63:0] ram_data_q, ram_data_d;
  logic        ram_wren_q, ram_wren_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;
  logic [15:0] words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif
  logic        take;

  assign take = in_valid && in_ready_q;

  // Next-state and next-output computation; all outputs are registered
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    pack_d        = pack_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    load_error_d  = load_error_q;
    words_d       = words_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_COLLECT;
          addr_d  = BASE_ADDRESS;
          idx_d   = 2'd0;
          words_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 16'd0;
`endif
        end
      end
      S_COLLECT: begin
        if (!load_start) begin
          state_d = S_IDLE;
        end else if (take) begin
          case (idx_q)
            2'd0:    pack_d[47:32] = in_data;
            2'd1:    pack_d[31:16] = in_data;
            2'd2:    pack_d[15:0]  = in_data;
            default: pack_d        = pack_q;
          endcase
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Fourth halfword completes the word: present it for exactly one write cycle
            state_d       = S_WRITE;
            ram_data_d    = {pack_q, in_data};
            ram_address_d = addr_q;
            words_d       = words_q + 16'd1;
          end
        end
      end
      S_WRITE: begin
        if (!load_start) begin
          state_d = S_IDLE;
        end else if (ram_data_q[63:48] == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d      = S_DONE;
          load_error_d = 1'b0;
`endif
        end else if (addr_q == 16'(DEPTH - 1)) begin
          // RAM full and the program has not ended: report overflow
          state_d      = S_DONE;
          load_error_d = 1'b1;
        end else begin
          state_d = S_COLLECT;
          addr_d  = addr_q + 16'd1;
          idx_d   = 2'd0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (!load_start) begin
          state_d = S_IDLE;
        end else if (take) begin
          state_d      = S_DONE;
          load_error_d = (in_data != csum_q);
        end
      end
`endif
      S_DONE: begin
        if (!load_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE drives every output to zero except the address, which parks at the base
    if (state_d == S_IDLE) begin
      ram_address_d = BASE_ADDRESS;
      ram_data_d    = 64'd0;
      load_error_d  = 1'b0;
      words_d       = 16'd0;
    end
`ifdef LOADER_CHECKSUM_EN
    in_ready_d  = (state_d == S_COLLECT) || (state_d == S_CHECK);
`else
    in_ready_d  = (state_d == S_COLLECT);
`endif
    ram_wren_d  = (state_d == S_WRITE);
    load_done_d = (state_d == S_DONE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      addr_q        <= BASE_ADDRESS;
      pack_q        <= 48'd0;
      in_ready_q    <= 1'b0;
      ram_address_q <= BASE_ADDRESS;
      ram_data_q    <= 64'd0;
      ram_wren_q    <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      words_q       <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      pack_q        <= pack_d;
      in_ready_q    <= in_ready_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      load_done_q   <= load_done_d;
      load_error_q  <= load_error_d;
      words_q       <= words_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign ram_address  = ram_address_q;
  assign ram_data     = ram_data_q;
  assign ram_wren     = ram_wren_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Testbench for instruction_ram_loader (DEPTH=4 so overflow is reachable).
// Expected RAM writes are queued as stimulus is driven and checked by a
// monitor whenever ram_wren is seen.
module tb_instruction_ram_loader;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ram_address;
  logic [63:0] ram_data;
  logic        ram_wren;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [79:0] exp_q[$];   // {address, data} of each expected write
  logic [15:0] prog_q[$];  // halfword program for the current load

  instruction_ram_loader #(.DEPTH(DEPTH), .BASE_ADDRESS(16'd0)) dut (
    .clock(clock), .reset_n(reset_n), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  // Write monitor: every write must match the next expected write
  always @(negedge clock) begin
    if (reset_n === 1'b1 && ram_wren === 1'b1) begin
      wr_count++;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL wren_in_ready: in_ready=%b required 0", in_ready);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write required", ram_address, ram_data);
      end else begin
        logic [79:0] e;
        e = exp_q.pop_front();
        if ({ram_address, ram_data} !== e)
          begin
            n_fail++;
            $display("FAIL write_data: addr=%h data=%h required addr=%h data=%h",
                     ram_address, ram_data, e[79:64], e[63:0]);
          end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one halfword and wait (bounded) until it is accepted
  task automatic send_hw(input logic [15:0] v, input bit gaps);
    int t;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
      end
    end
    in_data  = v;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 30) begin @(posedge clock); #1; t++; end
    if (t >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: halfword %h not accepted, in_ready=%b required 1", v, in_ready);
    end else begin
      @(posedge clock); #1;
    end
  endtask

  // Stream prog_q instruction by instruction, queueing each expected write
  task automatic stream_prog(input bit gaps);
    int n;
    n = prog_q.size() / 4;
    for (int i = 0; i < n && i < DEPTH; i++) begin
      exp_q.push_back({16'(i), prog_q[4*i], prog_q[4*i+1], prog_q[4*i+2], prog_q[4*i+3]});
      for (int k = 0; k < 4; k++) send_hw(prog_q[4*i+k], gaps);
    end
    in_valid = 1'b0;
  endtask

  // After the last instruction: send the checksum if built in, then wait for done
  task automatic complete_load(input logic [15:0] csum, output bit ok);
    int t;
`ifdef LOADER_CHECKSUM_EN
    send_hw(csum, 1'b0);
    in_valid = 1'b0;
`else
    if (csum == 16'hFFFF) ok = 1'b0;
`endif
    t = 0;
    while (load_done !== 1'b1 && t < 20) begin @(posedge clock); #1; t++; end
    ok = (load_done === 1'b1);
  endtask

  task automatic end_load();
    load_start = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (load_done !== 1'b0 || load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL end_ack: done=%b err=%b required 0 0", load_done, load_error);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 16'd0;
    #12;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: %b required 0", in_ready); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: %b required 0", ram_wren); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: %b required 0", load_done); end
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: %b required 0", load_error); end
    n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL reset_words: %h required 0", words_loaded); end
    n_checks++; if (ram_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: %h required 0", ram_data); end
    n_checks++; if (ram_address !== 16'd0) begin n_fail++; $display("FAIL reset_addr: %h required 0", ram_address); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    n_checks++;
    if (in_ready !== 1'b0 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: in_ready=%b done=%b required 0 0", in_ready, load_done);
    end
  endtask

  task automatic test_basic_load();
    int w0;
    bit ok;
    w0 = wr_count;
    prog_q = '{16'd3, 16'd5, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    load_start = 1'b1;
    stream_prog(1'b0);
    n_checks++;
    if (ram_wren !== 1'b1 || ram_address !== 16'd1) begin
      n_fail++;
      $display("FAIL eof_write_cycle: wren=%b addr=%h required 1 0001", ram_wren, ram_address);
    end
    @(posedge clock); #1;
`ifdef LOADER_CHECKSUM_EN
    n_checks++;
    if (in_ready !== 1'b1 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL check_state: in_ready=%b done=%b required 1 0", in_ready, load_done);
    end
    send_hw(16'd9, 1'b0);
    in_valid = 1'b0;
`endif
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: done=%b required 1", load_done); end
    ok = 1'b1;
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL basic_error: %b required 0", load_error); end
    n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL basic_words: %0d required 2", words_loaded); end
    n_checks++; if (wr_count - w0 != 2 || !ok) begin n_fail++; $display("FAIL basic_wren_pulses: %0d required 2", wr_count - w0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_pending: %0d writes missing required 0", exp_q.size()); end
    end_load();
    n_checks++; if (ram_address !== 16'd0) begin n_fail++; $display("FAIL idle_addr: %h required 0", ram_address); end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int run = 0; run < 2; run++) begin
      int w0;
      w0 = wr_count;
      prog_q = '{16'h000A, 16'h0001, 16'h0002, 16'h0003,
                 16'h000B, 16'h0004, 16'h0005, 16'h0006,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      load_start = 1'b1;
      stream_prog(run == 1);
      complete_load(16'd42, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done run%0d: done=%b required 1", run, load_done); end
      n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL bp_error run%0d: %b required 0", run, load_error); end
      n_checks++; if (words_loaded !== 16'd3) begin n_fail++; $display("FAIL bp_words run%0d: %0d required 3", run, words_loaded); end
      n_checks++; if (wr_count - w0 != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_writes run%0d: %0d required 3", run, wr_count - w0); end
      end_load();
    end
  endtask

  task automatic test_overflow();
    int w0;
    bit seen_ready;
    w0 = wr_count;
    prog_q = {};
    for (int i = 0; i < 5; i++) begin
      prog_q.push_back(16'h0021 + 16'(i));
      prog_q.push_back(16'h0100 + 16'(i));
      prog_q.push_back(16'h0200 + 16'(i));
      prog_q.push_back(16'h0300 + 16'(i));
    end
    load_start = 1'b1;
    stream_prog(1'b0);
    // Offer the fifth instruction: it must never be accepted
    in_data = prog_q[16];
    in_valid = 1'b1;
    seen_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (in_ready === 1'b1) seen_ready = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (seen_ready) begin n_fail++; $display("FAIL ovf_accept: in_ready=1 seen required 0"); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: %b required 1", load_done); end
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: %b required 1", load_error); end
    n_checks++; if (words_loaded !== 16'd4) begin n_fail++; $display("FAIL ovf_words: %0d required 4", words_loaded); end
    n_checks++; if (wr_count - w0 != 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_writes: %0d required 4", wr_count - w0); end
    end_load();
  endtask

  task automatic test_abort();
    int w0;
    bit ok;
    prog_q = '{16'h0011, 16'h0001, 16'h0002, 16'h0003};
    load_start = 1'b1;
    stream_prog(1'b0);
    send_hw(16'h0012, 1'b0);
    send_hw(16'h0007, 1'b0);
    in_valid = 1'b0;
    w0 = wr_count;
    load_start = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (in_ready !== 1'b0 || load_done !== 1'b0 || ram_address !== 16'd0 || words_loaded !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_idle: in_ready=%b done=%b addr=%h words=%0d required 0 0 0000 0",
               in_ready, load_done, ram_address, words_loaded);
    end
    repeat (6) begin @(posedge clock); #1; end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL abort_no_write: %0d writes required 0", wr_count - w0); end
    prog_q = '{16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_start = 1'b1;
    stream_prog(1'b0);
    complete_load(16'd34, ok);
    n_checks++; if (!ok || load_error !== 1'b0) begin n_fail++; $display("FAIL restart_done: done=%b err=%b required 1 0", load_done, load_error); end
    n_checks++; if (words_loaded !== 16'd2 || exp_q.size() != 0) begin n_fail++; $display("FAIL restart_words: %0d required 2", words_loaded); end
    end_load();
  endtask

  task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
    bit ok;
    for (int run = 0; run < 2; run++) begin
      prog_q = '{16'd3, 16'd5, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      load_start = 1'b1;
      stream_prog(1'b0);
      complete_load((run == 0) ? 16'd9 : 16'd8, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL csum_done run%0d: %b required 1", run, load_done); end
      n_checks++;
      if (load_error !== (run == 1)) begin
        n_fail++;
        $display("FAIL csum_error run%0d: %b required %0d", run, load_error, run);
      end
      n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL csum_words run%0d: %0d required 2", run, words_loaded); end
      end_load();
    end
`else
    prog_q = '{16'd0, 16'd0, 16'd0, 16'd0};
    load_start = 1'b1;
    stream_prog(1'b0);
    n_checks++; if (ram_wren !== 1'b1 || ram_address !== 16'd0) begin n_fail++; $display("FAIL eof_only_write: wren=%b addr=%h required 1 0000", ram_wren, ram_address); end
    @(posedge clock); #1;
    n_checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin n_fail++; $display("FAIL eof_only_done: done=%b err=%b required 1 0", load_done, load_error); end
    n_checks++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL eof_only_words: %0d required 1", words_loaded); end
    end_load();
`endif
  endtask

  task automatic test_async_reset();
    int w0;
    prog_q = '{16'h0031, 16'h0032, 16'h0033, 16'h0034};
    load_start = 1'b1;
    stream_prog(1'b0);
    send_hw(16'h0041, 1'b0);
    send_hw(16'h0042, 1'b0);
    w0 = wr_count;
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready: %b required 0", in_ready); end
    n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL areset_words: %0d required 0", words_loaded); end
    n_checks++; if (ram_data !== 64'd0 || ram_address !== 16'd0) begin n_fail++; $display("FAIL areset_ram: addr=%h data=%h required 0 0", ram_address, ram_data); end
    n_checks++; if (ram_wren !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl: wren=%b done=%b err=%b required 0 0 0", ram_wren, load_done, load_error); end
    in_valid = 1'b0;
    load_start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (6) begin @(posedge clock); #1; end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL areset_no_write: %0d writes required 0", wr_count - w0); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_overflow();
    test_abort();
    test_checksum();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_pending: %0d writes missing required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
